// File: rtl/fp_normalize_pipe_pkg.sv
// ----------------------------------------------------------------------------
// fp_norm_pkg
// Shared types and constants for the floating-point mantissa normaliser.
//   NORM_MW / NORM_EW : datapath widths (significand incl. hidden bit, exponent)
//   LZW               : leading-zero count width, clog2(MW+1)
//   EXP_ONES          : all-ones biased exponent (infinity)
//   norm_res_t        : registered result payload (mant, exp, flags)
// Optional feature macro: NORM_STICKY_EN adds the sticky flag to the payload.
// ----------------------------------------------------------------------------
package fp_norm_pkg;

    localparam int unsigned NORM_MW = 24;
    localparam int unsigned NORM_EW = 8;

    // Width of a leading-zero count able to represent 0..mw inclusive
    function automatic int unsigned lzw_of(input int unsigned mw);
        return $clog2(mw + 1);
    endfunction

    localparam int unsigned LZW = $clog2(NORM_MW + 1);

    localparam logic [NORM_EW-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic [NORM_MW-1:0] mant;
        logic [NORM_EW-1:0] exp;
        logic               zero;
        logic               denorm;
        logic               ovf;
`ifdef NORM_STICKY_EN
        logic               sticky;
`endif
    } norm_res_t;

endpackage

// File: rtl/fp_normalize_pipe_if.sv
// ----------------------------------------------------------------------------
// fp_normalize_pipe_if
// Valid/ready operand and result channels of the mantissa normaliser.
//   in_*      : operand channel (carry, raw significand, tentative exponent)
//   out_*     : normalised result channel with zero/denorm/ovf flags
//   slave     : normaliser side; master : producer/consumer side
// Optional feature macro: NORM_STICKY_EN adds out_sticky.
// ----------------------------------------------------------------------------
interface fp_normalize_pipe_if #(
    parameter int unsigned MW = 24,
    parameter int unsigned EW = 8
);

    logic          in_valid;
    logic          in_ready;
    logic          in_carry;
    logic [MW-1:0] in_mant;
    logic [EW-1:0] in_exp;

    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_denorm;
    logic          out_ovf;
`ifdef NORM_STICKY_EN
    logic          out_sticky;
`endif

`ifdef NORM_STICKY_EN
    modport slave (
        input  in_valid, in_carry, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp,
               out_zero, out_denorm, out_ovf, out_sticky
    );

    modport master (
        output in_valid, in_carry, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp,
               out_zero, out_denorm, out_ovf, out_sticky
    );
`else
    modport slave (
        input  in_valid, in_carry, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp,
               out_zero, out_denorm, out_ovf
    );

    modport master (
        output in_valid, in_carry, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp,
               out_zero, out_denorm, out_ovf
    );
`endif

endinterface

// File: rtl/fp_normalize_pipe_lzc.sv
// ----------------------------------------------------------------------------
// norm_lzc
// Combinational leading-zero counter.
//   i_mant : MW-bit significand
//   o_lz_c : number of leading zeros, MW when i_mant is all-zero
// ----------------------------------------------------------------------------
module norm_lzc #(
    parameter int unsigned MW  = 24,
    parameter int unsigned LZW = $clog2(MW + 1)
) (
    input  logic [MW-1:0]  i_mant,
    output logic [LZW-1:0] o_lz_c
);

    // Scan from LSB upward; the last set bit seen is the most significant one
    always_comb begin : p_lzc
        logic [MW-1:0] w_scan;
        w_scan = i_mant;
        o_lz_c = LZW'(MW);
        for (int unsigned i = 0; i < MW; i++) begin
            if (w_scan[0]) begin
                o_lz_c = LZW'(MW - 1 - i);
            end
            w_scan = w_scan >> 1;
        end
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// ----------------------------------------------------------------------------
// fp_normalize_pipe
// Two-stage pipelined mantissa normaliser for the FP adder. Stage 1 registers
// the operand and its leading-zero count; stage 2 computes and holds the
// normalised result (carry right-shift, left-shift with exponent decrement,
// underflow to denormal, overflow to infinity, exact zero).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, flushes both stages
//   bus  : fp_normalize_pipe_if.slave operand/result channels
// MW/EW must match the payload widths in fp_norm_pkg.
// Optional feature macro: NORM_STICKY_EN adds out_sticky (bit lost on carry).
// ----------------------------------------------------------------------------
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int unsigned MW = NORM_MW,
    parameter int unsigned EW = NORM_EW
) (
    input  logic                    clk,
    input  logic                    rst,
    fp_normalize_pipe_if.slave      bus
);

    localparam int unsigned LZ_W = lzw_of(MW);
    localparam int unsigned XW   = EW + 1;

    // Stage 1 registers
    logic            r_s1_valid;
    logic            r_s1_carry;
    logic [MW-1:0]   r_s1_mant;
    logic [EW-1:0]   r_s1_exp;
    logic [LZ_W-1:0] r_s1_lz;

    // Stage 2 (output) registers
    logic            r_s2_valid;
    norm_res_t       r_res;

    logic [LZ_W-1:0] w_lz;
    logic            w_s2_load;
    logic            w_s1_adv;
    logic            w_in_ready;
    norm_res_t       w_res;
    logic [XW-1:0]   w_exp_x;
    logic [XW-1:0]   w_exp_inc;
    logic [XW-1:0]   w_lz_x;
    logic [XW-1:0]   w_ushift;

    norm_lzc #(
        .MW  (MW),
        .LZW (LZ_W)
    ) u_lzc (
        .i_mant (bus.in_mant),
        .o_lz_c (w_lz)
    );

    // Ready chain: combinational from out_ready back to in_ready
    assign w_s2_load  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = w_s2_load;
    assign w_in_ready = !r_s1_valid || w_s1_adv;

    // Stage 1: capture operand and its leading-zero count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_carry <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_lz    <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_carry <= bus.in_carry;
                r_s1_mant  <= bus.in_mant;
                r_s1_exp   <= bus.in_exp;
                r_s1_lz    <= w_lz;
            end
        end
    end

    // Stage 2 datapath: cases in priority order zero, carry, normal, underflow.
    // Exponent arithmetic is done one bit wider so nothing wraps.
    always_comb begin
        w_res     = '0;
        w_exp_x   = {1'b0, r_s1_exp};
        w_exp_inc = w_exp_x + XW'(1);
        w_lz_x    = XW'(r_s1_lz);
        w_ushift  = '0;

        if (!r_s1_carry && (r_s1_mant == '0)) begin
            w_res.zero = 1'b1;
        end else if (r_s1_carry) begin
            if (w_exp_inc >= XW'(EXP_ONES)) begin
                w_res.ovf = 1'b1;
                w_res.exp = EW'(EXP_ONES);
            end else begin
                w_res.mant = {1'b1, r_s1_mant[MW-1:1]};
                w_res.exp  = EW'(w_exp_inc);
`ifdef NORM_STICKY_EN
                w_res.sticky = r_s1_mant[0];
`endif
            end
        end else if (w_lz_x < w_exp_x) begin
            w_res.mant = r_s1_mant << r_s1_lz;
            w_res.exp  = EW'(w_exp_x - w_lz_x);
        end else begin
            // Shift only until the exponent reaches the denormal scale
            w_ushift     = (w_exp_x == '0) ? '0 : (w_exp_x - XW'(1));
            w_res.mant   = r_s1_mant << w_ushift;
            w_res.denorm = 1'b1;
        end
    end

    // Stage 2 register: loads when empty or when the consumer accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res <= w_res;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out_mant   = r_res.mant;
    assign bus.out_exp    = r_res.exp;
    assign bus.out_zero   = r_res.zero;
    assign bus.out_denorm = r_res.denorm;
    assign bus.out_ovf    = r_res.ovf;
`ifdef NORM_STICKY_EN
    assign bus.out_sticky = r_res.sticky;
`endif

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_normalize_pipe
// Directed self-checking bench for fp_normalize_pipe (MW=24, EW=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_fp_normalize_pipe;

    localparam int unsigned MW = 24;
    localparam int unsigned EW = 8;

`ifdef NORM_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_normalize_pipe_if #(.MW(MW), .EW(EW)) u_if ();

    fp_normalize_pipe #(.MW(MW), .EW(EW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Observed flags packed as {zero, denorm, ovf, sticky}
    function automatic logic [3:0] obs_flags();
`ifdef NORM_STICKY_EN
        return {u_if.out_zero, u_if.out_denorm, u_if.out_ovf, u_if.out_sticky};
`else
        return {u_if.out_zero, u_if.out_denorm, u_if.out_ovf, 1'b0};
`endif
    endfunction

    task automatic chk_out(input string tag, input logic [MW-1:0] m,
                           input logic [EW-1:0] e, input logic [3:0] f);
        chk({tag, ".valid"}, 32'(u_if.out_valid), 32'd1);
        chk({tag, ".mant"},  32'(u_if.out_mant),  32'(m));
        chk({tag, ".exp"},   32'(u_if.out_exp),   32'(e));
        chk({tag, ".flags"}, 32'(obs_flags()),    32'({f[3:1], f[0] & STICKY_EN}));
    endtask

    // One isolated operand: accept, check latency, then check the result
    task automatic run_vec(input string tag, input logic c, input logic [MW-1:0] mi,
                           input logic [EW-1:0] ei, input logic [MW-1:0] mo,
                           input logic [EW-1:0] eo, input logic [3:0] f);
        @(negedge clk);
        u_if.in_valid  = 1'b1;
        u_if.in_carry  = c;
        u_if.in_mant   = mi;
        u_if.in_exp    = ei;
        u_if.out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(u_if.in_ready), 32'd1);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        chk({tag, ".lat1"}, 32'(u_if.out_valid), 32'd0);
        @(negedge clk);
        chk_out(tag, mo, eo, f);
    endtask

    logic [MW-1:0] bp_mi [5];
    logic [EW-1:0] bp_ei [5];
    logic [MW-1:0] bp_mo [5];
    logic [EW-1:0] bp_eo [5];

    initial begin
        int tx;
        int rx;

        rst            = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.in_carry  = 1'b0;
        u_if.in_mant   = '0;
        u_if.in_exp    = '0;
        u_if.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.out_valid", 32'(u_if.out_valid), 32'd0);
        chk("reset.in_ready",  32'(u_if.in_ready),  32'd1);
        chk("reset.mant",      32'(u_if.out_mant),  32'd0);
        chk("reset.exp",       32'(u_if.out_exp),   32'd0);
        chk("reset.flags",     32'(obs_flags()),    32'd0);

        // Directed single-operand vectors, flags = {zero, denorm, ovf, sticky}
        run_vec("normal",     1'b0, 24'h000800, 8'h80, 24'h800000, 8'h74, 4'b0000);
        run_vec("carry",      1'b1, 24'h800001, 8'h7F, 24'hC00000, 8'h80, 4'b0001);
        run_vec("ovf",        1'b1, 24'hFFFFFF, 8'hFE, 24'h000000, 8'hFF, 4'b0010);
        run_vec("underflow",  1'b0, 24'h000001, 8'h05, 24'h000010, 8'h00, 4'b0100);
        run_vec("zero",       1'b0, 24'h000000, 8'h33, 24'h000000, 8'h00, 4'b1000);
        run_vec("passthru",   1'b0, 24'h800000, 8'h10, 24'h800000, 8'h10, 4'b0000);
        run_vec("lz_exp_m1",  1'b0, 24'h000800, 8'h0D, 24'h800000, 8'h01, 4'b0000);
        run_vec("lz_eq_exp",  1'b0, 24'h000800, 8'h0C, 24'h400000, 8'h00, 4'b0100);
        run_vec("exp0_den",   1'b0, 24'h000100, 8'h00, 24'h000100, 8'h00, 4'b0100);
        run_vec("carry_even", 1'b1, 24'h000002, 8'h10, 24'h800001, 8'h11, 4'b0000);
        run_vec("carry_m0",   1'b1, 24'h000000, 8'h20, 24'h800000, 8'h21, 4'b0000);
        run_vec("carry_fd",   1'b1, 24'h000003, 8'hFD, 24'h800001, 8'hFE, 4'b0001);

        // Backpressure: 5 back-to-back operands, out_ready low in cycles 3..5
        for (int k = 0; k < 5; k++) begin
            bp_mi[k] = MW'(32'h400000 | (32'(k) << 4));
            bp_ei[k] = EW'(32'h40 + 32'(k));
            bp_mo[k] = MW'(32'h800000 | (32'(k) << 5));
            bp_eo[k] = EW'(32'h3F + 32'(k));
        end
        tx = 0;
        rx = 0;
        for (int c = 1; c <= 40 && rx < 5; c++) begin
            @(negedge clk);
            u_if.out_ready = !(c >= 3 && c <= 5);
            if (tx < 5) begin
                u_if.in_valid = 1'b1;
                u_if.in_carry = 1'b0;
                u_if.in_mant  = bp_mi[tx];
                u_if.in_exp   = bp_ei[tx];
            end else begin
                u_if.in_valid = 1'b0;
            end
            #1;
            if (c == 3) chk("bp.in_ready_full", 32'(u_if.in_ready), 32'd0);
            if (u_if.out_valid) begin
                chk_out(u_if.out_ready ? "bp.result" : "bp.hold", bp_mo[rx], bp_eo[rx], 4'b0000);
                if (u_if.out_ready) rx++;
            end
            if (u_if.in_valid && u_if.in_ready) tx++;
        end
        chk("bp.rx_count", 32'(rx), 32'd5);
        chk("bp.tx_count", 32'(tx), 32'd5);
        @(negedge clk);
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp.no_dup", 32'(u_if.out_valid), 32'd0);
        end

        // Reset with both stages full
        @(negedge clk);
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_carry  = 1'b1;
        u_if.in_mant   = 24'h800001;
        u_if.in_exp    = 8'h40;
        @(negedge clk);
        u_if.in_carry  = 1'b0;
        u_if.in_mant   = 24'h000800;
        u_if.in_exp    = 8'h80;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        #1;
        chk("rst.full_in_ready", 32'(u_if.in_ready), 32'd0);
        chk("rst.full_out_valid", 32'(u_if.out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst.in_ready",  32'(u_if.in_ready),  32'd1);
        chk("rst.mant",      32'(u_if.out_mant),  32'd0);
        chk("rst.exp",       32'(u_if.out_exp),   32'd0);
        chk("rst.flags",     32'(obs_flags()),    32'd0);
        rst = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst.no_stale", 32'(u_if.out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_normalize_pipe.md
# fp_normalize_pipe

Parametrised, two-stage pipelined mantissa normaliser with valid/ready handshaking. It sits after the significand add/subtract stage of the floating-point adder and turns a raw sum and its tentative exponent into a normalised result. It handles carry-out (right shift by one), leading-zero left shift with exponent decrement, exponent underflow to denormal, exponent overflow, and zero. It accepts one operand per cycle and has a fixed two-cycle latency.

## Interface
Parameters:
- MW, 24, significand width including hidden bit.
- EW, 8, biased exponent width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_carry  in  1  carry-out of the significand adder (bit MW).
- in_mant  in  MW  raw significand.
- in_exp  in  EW  tentative biased exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_mant  out  MW  normalised significand.
- out_exp  out  EW  adjusted exponent.
- out_zero  out  1  result is exact zero.
- out_denorm  out  1  underflow; result is denormal, with out_exp = 0.
- out_ovf  out  1  exponent overflow; result is infinity.
- out_sticky  out  1  bit lost in the right shift (present only with NORM_STICKY_EN).

## Operation
- Transfers happen on a cycle where valid and ready are both high at that port.
- Stage 1 registers the operand, the carry and the leading-zero count lz of in_mant. lz is clog2(MW+1) bits wide; lz = MW when in_mant = 0.
- Stage 2 computes the result and is the output register. Cases are evaluated in priority order:
  - Zero: in_carry = 0 and in_mant = 0 gives out_mant = 0, out_exp = 0, out_zero = 1.
  - Carry: in_carry = 1 gives out_mant = {1, in_mant[MW-1:1]}, out_exp = in_exp + 1.
    - If in_exp + 1 = all-ones, then out_ovf = 1, out_exp = all-ones, out_mant = 0.
  - Normal: 0 ≤ lz < in_exp gives out_mant = in_mant << lz, out_exp = in_exp − lz.
  - Underflow: lz ≥ in_exp gives out_mant = in_mant << (in_exp = 0 ? 0 : in_exp − 1), out_exp = 0, out_denorm = 1.
- Flags are mutually exclusive. An already-normalised input (lz = 0, in_exp ≥ 1) passes through unchanged.
- Subtraction uses EW+1-bit width internally; no wrap-around is permitted.

## Timing
- Reset: both stage valids clear; all outputs read 0. in_ready = 1 in the first cycle after reset.
- Reset in mid-operation flushes both stages. In-flight operands are dropped and out_valid falls in the next cycle.
- Latency: an operand accepted in cycle N appears with out_valid = 1 in cycle N+2, if the output is not stalled.
- Throughput: one operand per cycle while out_ready = 1.
- Ready chain:
  - Stage 2 loads when it is empty or out_ready = 1.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || stage-1-advances. This path is combinational from out_ready.
- Stall: while out_valid = 1 and out_ready = 0, all out_* signals hold stable. At most two operands are buffered; in_ready drops once both stages are full.
- A simultaneous accept at the input and output in the same cycle with both stages full is legal and loses no data.
- Results leave in input order.

## Configuration
- NORM_STICKY_EN defined:
  - out_sticky exists.
  - It equals in_mant[0] on the carry path and 0 on every other path, including overflow.
  - It is registered with the result and reset to 0.
- NORM_STICKY_EN undefined: the out_sticky port and its logic are absent. All other behaviour is identical.

## Structure
- Package fp_norm_pkg holds:
  - localparam LZW = $clog2(MW+1) helper;
  - a struct holding the mant/exp/flag fields of the result;
  - the all-ones exponent constant.
- One sub-module, norm_lzc: a parametrised, combinational leading-zero counter (MW in, LZW out, returns MW for all-zero). It is instantiated in stage 1.

## Test plan
All cases use MW=24, EW=8.
- Normal left shift: mant 0x000800, exp 0x80, carry 0 → 2 cycles later mant 0x800000, exp 0x74, all flags 0.
- Carry path: carry 1, mant 0x800001, exp 0x7F → mant 0xC00000, exp 0x80; out_sticky = 1 with NORM_STICKY_EN.
- Overflow: carry 1, mant 0xFFFFFF, exp 0xFE → exp 0xFF, mant 0, out_ovf = 1.
- Underflow and zero:
  - mant 0x000001, exp 0x05 → mant 0x000010, exp 0, out_denorm = 1.
  - mant 0, carry 0 → out_zero = 1, exp 0.
- Backpressure: stream 5 back-to-back operands with out_ready low for cycles 3–5.
  - in_ready falls after two operands are buffered.
  - All 5 results emerge in order, with no duplicates.
  - Outputs hold stable during the stall.
- Reset mid-stream: assert rst with both stages full → next cycle out_valid = 0, in_ready = 1, all outputs 0; no stale result appears.
